fsim_run_ctrl: RTL and testbench
================================

# fsim_run_ctrl

Synthesizable run sequencer for the fault-simulation bench around the core under test. On request it holds the core in reset for a programmed number of cycles, releases it while emitting a one-cycle fault-injection request, then paces compare strobes while the test program runs. It closes the run on end-of-test (with a drain window) or on cycle timeout. It replaces free-running per-clock compare strobing with deterministic, counted strobe windows that bench and fault simulator both key off.

## Interface
- CNT_W, 32: width of run-cycle counter and timeout value.
- RST_CYCLES, 8: cycles core reset is held after start (≥1).
- STROBE_DIV, 1: strobe every STROBE_DIV RUN cycles (≥1; 1 = every cycle).
- DRAIN_CYCLES, 4: cycles strobed after end-of-test (0 allowed).

- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a run; sampled only in IDLE.
- abort_i  in  1  return to IDLE from any state next cycle.
- timeout_i  in  CNT_W  max RUN cycles, captured on start; 0 = no timeout.
- eot_i  in  1  core end-of-test indication; sampled only in RUN.
- core_rst_no  out  1  active-low reset to core under test.
- inject_o  out  1  one-cycle fault-injection request.
- strobe_o  out  1  compare strobe, valid for the current cycle.
- busy_o  out  1  state ≠ IDLE.
- done_o  out  1  sticky: last run ended by eot_i.
- timeout_o  out  1  sticky: last run ended by timeout.
- cycle_cnt_o  out  CNT_W  RUN cycles elapsed in current/last run.

## Operation
- FSM states: IDLE, RST, INJ, RUN, DRAIN. Outputs are decoded from registered state plus registered counters (Moore); no combinational input-to-output path.
- IDLE: core_rst_no=0. start_i=1 → RST; clears done_o, timeout_o, cycle_cnt_o; captures timeout_i into timeout_q.
- RST: core_rst_no=0 for exactly RST_CYCLES cycles, then → INJ.
- INJ: one cycle, core_rst_no=1, inject_o=1 → RUN. Divider counter cleared.
- RUN: core_rst_no=1. strobe_o=1 when divider=0; divider counts 0..STROBE_DIV-1 and wraps. cycle_cnt_o increments every RUN cycle, saturating at all-ones.
  - eot_i=1 → DRAIN (→ IDLE with done_o=1 if DRAIN_CYCLES=0). The eot cycle is counted and strobed per divider.
  - Else if timeout_q≠0 and cycle_cnt_o = timeout_q-1 → IDLE, timeout_o=1, no drain.
  - eot_i and timeout in the same cycle: eot wins.
- DRAIN: core_rst_no=1, strobe_o=1 every cycle for DRAIN_CYCLES cycles, then → IDLE with done_o=1. cycle_cnt_o frozen.
- abort_i (any non-IDLE state) → IDLE next cycle; done_o, timeout_o remain 0; cycle_cnt_o frozen. abort_i has priority over eot/timeout.
- start_i outside IDLE ignored.

## Timing
- Reset values: core_rst_no=0, inject_o=0, strobe_o=0, busy_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0, state IDLE.
- start_i high at edge t → busy_o=1 from t+1; core_rst_no low t+1..t+RST_CYCLES; inject_o high in cycle t+RST_CYCLES+1; first RUN cycle t+RST_CYCLES+2 with strobe_o=1.
- done_o/timeout_o rise in the first IDLE cycle, together with busy_o falling.
- rst_i mid-run: all outputs at reset values next cycle; core_rst_no=0 immediately after the edge.
- Back-to-back runs: start_i held high re-enters RST from the first IDLE cycle; flags cleared on that transition.

## Test plan
- rst_i for 3 cycles → all outputs at reset values; start_i ignored while rst_i=1.
- Defaults, start, eot_i on 20th RUN cycle → core_rst_no low 8 cycles, exactly 1 inject_o pulse, 24 strobes (20+4), done_o=1, cycle_cnt_o=20, timeout_o=0.
- STROBE_DIV=3, eot_i on 9th RUN cycle, DRAIN_CYCLES=0 → strobes on RUN cycles 1,4,7 only (3 total), done_o=1 next cycle.
- timeout_i=5, no eot → RUN lasts 5 cycles, timeout_o=1, done_o=0, no drain strobes, cycle_cnt_o=5; repeat with eot_i on 5th cycle → done_o=1, 4 drain strobes.
- abort_i in RST cycle 3 → no inject_o, IDLE next cycle, flags 0; abort_i in DRAIN → strobing stops next cycle, done_o=0.
- rst_i in RUN cycle 10 → outputs reset next cycle; new start afterwards completes normally with cycle_cnt_o counting from 0.

Source files
------------

// File: rtl/fsim_run_ctrl.sv
// Run sequencer for the fault-simulation bench: holds the core in reset, pulses
// fault injection on release, paces compare strobes, and closes on end-of-test or timeout.
module fsim_run_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned STROBE_DIV   = 1,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] timeout_i,
  input  logic             eot_i,
  output logic             core_rst_no,
  output logic             inject_o,
  output logic             strobe_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int unsigned PH_MAX     = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PH_W       = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned DIV_W      = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
  localparam int unsigned RST_LAST   = RST_CYCLES - 1;
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned DIV_LAST   = STROBE_DIV - 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_INJ   = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [PH_W-1:0]   r_ph;
  logic [PH_W-1:0]   w_ph_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  w_div_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  r_tq;
  logic [CNT_W-1:0]  w_tq_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_tmo;
  logic              w_tmo_nxt;
  logic [CNT_W-1:0]  w_cnt_sat;
  logic              w_tmo_hit;

  assign w_cnt_sat = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_tmo_hit = (r_tq != '0) && (r_cnt == r_tq - CNT_W'(1));

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_tq    <= '0;
      r_done  <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ph    <= w_ph_nxt;
      r_div   <= w_div_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tq    <= w_tq_nxt;
      r_done  <= w_done_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  // Next-state and datapath update
  always_comb begin
    w_next     = r_state;
    w_ph_nxt   = r_ph;
    w_div_nxt  = r_div;
    w_cnt_nxt  = r_cnt;
    w_tq_nxt   = r_tq;
    w_done_nxt = r_done;
    w_tmo_nxt  = r_tmo;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next     = S_RST;
          w_ph_nxt   = '0;
          w_cnt_nxt  = '0;
          w_tq_nxt   = timeout_i;
          w_done_nxt = 1'b0;
          w_tmo_nxt  = 1'b0;
        end
      end
      S_RST: begin
        if (r_ph == PH_W'(RST_LAST)) begin
          w_next   = S_INJ;
          w_ph_nxt = '0;
        end else begin
          w_ph_nxt = r_ph + PH_W'(1);
        end
      end
      S_INJ: begin
        w_next    = S_RUN;
        w_div_nxt = '0;
      end
      S_RUN: begin
        w_cnt_nxt = w_cnt_sat;
        w_div_nxt = (r_div == DIV_W'(DIV_LAST)) ? '0 : r_div + DIV_W'(1);
        // End-of-test outranks a coincident timeout
        if (eot_i) begin
          if (DRAIN_CYCLES == 0) begin
            w_next     = S_IDLE;
            w_done_nxt = 1'b1;
          end else begin
            w_next   = S_DRAIN;
            w_ph_nxt = '0;
          end
        end else if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_tmo_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_ph == PH_W'(DRAIN_LAST)) begin
          w_next     = S_IDLE;
          w_done_nxt = 1'b1;
        end else begin
          w_ph_nxt = r_ph + PH_W'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase

    // Abort leaves flags clear and the cycle count frozen
    if (abort_i && (r_state != S_IDLE)) begin
      w_next     = S_IDLE;
      w_cnt_nxt  = r_cnt;
      w_done_nxt = r_done;
      w_tmo_nxt  = r_tmo;
    end
  end

  assign core_rst_no = (r_state == S_INJ) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign inject_o    = (r_state == S_INJ);
  assign strobe_o    = ((r_state == S_RUN) && (r_div == '0)) || (r_state == S_DRAIN);
  assign busy_o      = (r_state != S_IDLE);
  assign done_o      = r_done;
  assign timeout_o   = r_tmo;
  assign cycle_cnt_o = r_cnt;

endmodule

// File: tb/tb_fsim_run_ctrl.sv
// Bench for fsim_run_ctrl: two instances (default, and STROBE_DIV=3 / DRAIN_CYCLES=0)
// checked cycle by cycle against a timeline model of a run.
module tb_fsim_run_ctrl;

  localparam int RST_N = 8;

  typedef struct {
    bit rstn, inj, stb, busy, done, tmo;
    int cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, abort_i, eot_i;
  logic [31:0] timeout_i;
  logic [1:0]  o_rstn, o_inj, o_stb, o_busy, o_done, o_tmo;
  logic [31:0] o_cnt [2];

  int errors = 0;
  int checks = 0;
  int g_eot, g_to, g_kill;
  bit g_kill_rst;
  int st_cnt [2];
  int inj_cnt [2];
  int rl_cnt [2];

  always #5 clk = ~clk;

  fsim_run_ctrl #(.CNT_W(32), .RST_CYCLES(8), .STROBE_DIV(1), .DRAIN_CYCLES(4)) u_a (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .timeout_i(timeout_i), .eot_i(eot_i),
    .core_rst_no(o_rstn[0]), .inject_o(o_inj[0]), .strobe_o(o_stb[0]),
    .busy_o(o_busy[0]), .done_o(o_done[0]), .timeout_o(o_tmo[0]), .cycle_cnt_o(o_cnt[0])
  );

  fsim_run_ctrl #(.CNT_W(32), .RST_CYCLES(8), .STROBE_DIV(3), .DRAIN_CYCLES(0)) u_b (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .timeout_i(timeout_i), .eot_i(eot_i),
    .core_rst_no(o_rstn[1]), .inject_o(o_inj[1]), .strobe_o(o_stb[1]),
    .busy_o(o_busy[1]), .done_o(o_done[1]), .timeout_o(o_tmo[1]), .cycle_cnt_o(o_cnt[1])
  );

  function automatic int div_of(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int drn_of(int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic bit eoe_of();
    return (g_eot > 0) && ((g_to == 0) || (g_eot <= g_to));
  endfunction

  function automatic int kend_of();
    return eoe_of() ? g_eot : g_to;
  endfunction

  // Last busy cycle (cycles counted from the start edge) of an undisturbed run
  function automatic int lb_of(int i);
    return RST_N + 1 + kend_of() + (eoe_of() ? drn_of(i) : 0);
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.rstn = 0; e.inj = 0; e.stb = 0; e.busy = 0; e.done = 0; e.tmo = 0; e.cnt = 0;
    return e;
  endfunction

  function automatic exp_t nat(int i, int c);
    exp_t e;
    int   k;
    e = zero_exp();
    k = c - RST_N - 1;
    if (c <= RST_N) begin
      e.busy = 1;
    end else if (c == RST_N + 1) begin
      e.busy = 1; e.rstn = 1; e.inj = 1;
    end else if (k <= kend_of()) begin
      e.busy = 1; e.rstn = 1; e.stb = ((k - 1) % div_of(i)) == 0; e.cnt = k - 1;
    end else if (c <= lb_of(i)) begin
      e.busy = 1; e.rstn = 1; e.stb = 1; e.cnt = kend_of();
    end else begin
      e.cnt = kend_of(); e.done = eoe_of(); e.tmo = !eoe_of();
    end
    return e;
  endfunction

  function automatic exp_t model(int i, int c);
    exp_t e;
    exp_t frozen;
    if (g_kill > 0 && c > g_kill) begin
      if (g_kill_rst) return zero_exp();
      if (g_kill <= lb_of(i)) begin
        frozen = nat(i, g_kill);
        e = zero_exp();
        e.cnt = frozen.cnt;
        return e;
      end
    end
    return nat(i, c);
  endfunction

  function automatic int end_of(int i);
    if (g_kill > 0 && (g_kill_rst || g_kill <= lb_of(i))) return g_kill + 1;
    return lb_of(i) + 1;
  endfunction

  // Drive one run from the current (idle) cycle and compare every following cycle
  task automatic run_scn(input string name, input int eot, input int to, input int kill, input bit kill_rst);
    exp_t       e;
    int         last;
    logic [5:0] got, want;
    g_eot = eot; g_to = to; g_kill = kill; g_kill_rst = kill_rst;
    last = (end_of(0) > end_of(1)) ? end_of(0) : end_of(1);
    for (int i = 0; i < 2; i++) begin
      st_cnt[i] = 0; inj_cnt[i] = 0; rl_cnt[i] = 0;
    end
    for (int c = 0; c < last; c++) begin
      start_i   = (c == 0);
      timeout_i = (c == 0) ? 32'(to) : $urandom;
      eot_i     = (eot > 0) && (c == RST_N + 1 + eot);
      abort_i   = !kill_rst && (kill > 0) && (c == kill);
      rst_i     = kill_rst && (kill > 0) && (c == kill);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        e    = model(i, c + 1);
        got  = {o_rstn[i], o_inj[i], o_stb[i], o_busy[i], o_done[i], o_tmo[i]};
        want = {e.rstn, e.inj, e.stb, e.busy, e.done, e.tmo};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s ctl inst%0d cyc%0d got=%b want=%b (rstn,inj,stb,busy,done,tmo)",
                   name, i, c + 1, got, want);
        end
        checks++;
        if (o_cnt[i] !== 32'(e.cnt)) begin
          errors++;
          $display("FAIL %s cnt inst%0d cyc%0d got=%0d want=%0d", name, i, c + 1, o_cnt[i], e.cnt);
        end
        if (o_stb[i] === 1'b1) st_cnt[i]++;
        if (o_inj[i] === 1'b1) inj_cnt[i]++;
        if (o_busy[i] === 1'b1 && o_rstn[i] === 1'b0) rl_cnt[i]++;
      end
    end
    start_i = 0; eot_i = 0; abort_i = 0; rst_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1; start_i = 1; abort_i = 0; eot_i = 0; timeout_i = 32'd3;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_rstn, o_inj, o_stb, o_busy, o_done, o_tmo} !== 12'd0 || o_cnt[0] !== 0 || o_cnt[1] !== 0) begin
        errors++;
        $display("FAIL reset cyc%0d got=%b cnt=%0d/%0d want all zero", n,
                 {o_rstn, o_inj, o_stb, o_busy, o_done, o_tmo}, o_cnt[0], o_cnt[1]);
      end
    end
    rst_i = 0; start_i = 0;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle busy got=%b want=00", o_busy);
    end
  endtask

  task automatic test_eot_default();
    run_scn("eot20", 20, 0, 0, 0);
    checks++;
    if (rl_cnt[0] !== 8 || inj_cnt[0] !== 1 || st_cnt[0] !== 24) begin
      errors++;
      $display("FAIL eot20_counts rstlow=%0d inj=%0d stb=%0d want 8/1/24", rl_cnt[0], inj_cnt[0], st_cnt[0]);
    end
    checks++;
    if (o_done[0] !== 1'b1 || o_tmo[0] !== 1'b0 || o_cnt[0] !== 32'd20) begin
      errors++;
      $display("FAIL eot20_final done=%b tmo=%b cnt=%0d want 1/0/20", o_done[0], o_tmo[0], o_cnt[0]);
    end
  endtask

  task automatic test_div3();
    run_scn("div3", 9, 0, 0, 0);
    checks++;
    if (st_cnt[1] !== 3 || o_done[1] !== 1'b1 || o_cnt[1] !== 32'd9) begin
      errors++;
      $display("FAIL div3_final stb=%0d done=%b cnt=%0d want 3/1/9", st_cnt[1], o_done[1], o_cnt[1]);
    end
  endtask

  task automatic test_timeout();
    run_scn("tmo5", 0, 5, 0, 0);
    checks++;
    if (o_tmo[0] !== 1'b1 || o_done[0] !== 1'b0 || st_cnt[0] !== 5 || o_cnt[0] !== 32'd5) begin
      errors++;
      $display("FAIL tmo5_final tmo=%b done=%b stb=%0d cnt=%0d want 1/0/5/5", o_tmo[0], o_done[0], st_cnt[0], o_cnt[0]);
    end
    run_scn("tmo5_eot5", 5, 5, 0, 0);
    checks++;
    if (o_done[0] !== 1'b1 || o_tmo[0] !== 1'b0 || st_cnt[0] !== 9) begin
      errors++;
      $display("FAIL tmo5_eot5_final done=%b tmo=%b stb=%0d want 1/0/9", o_done[0], o_tmo[0], st_cnt[0]);
    end
  endtask

  task automatic test_abort();
    run_scn("abort_rst", 15, 0, 3, 0);
    checks++;
    if (inj_cnt !== '{0, 0} || o_busy !== 2'b00 || o_done !== 2'b00 || o_tmo !== 2'b00) begin
      errors++;
      $display("FAIL abort_rst inj=%0d/%0d busy=%b done=%b tmo=%b want none", inj_cnt[0], inj_cnt[1], o_busy, o_done, o_tmo);
    end
    run_scn("abort_drain", 6, 0, RST_N + 1 + 6 + 2, 0);
    checks++;
    if (st_cnt[0] !== 8 || o_done[0] !== 1'b0 || o_tmo[0] !== 1'b0 || o_done[1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_drain stb=%0d done=%b tmo=%b doneB=%b want 8/0/0/1", st_cnt[0], o_done[0], o_tmo[0], o_done[1]);
    end
  endtask

  task automatic test_rst_midrun();
    run_scn("rst_mid", 0, 30, RST_N + 1 + 10, 1);
    run_scn("after_rst", 12, 0, 0, 0);
    checks++;
    if (o_cnt[0] !== 32'd12 || o_done[0] !== 1'b1 || inj_cnt[0] !== 1) begin
      errors++;
      $display("FAIL after_rst cnt=%0d done=%b inj=%0d want 12/1/1", o_cnt[0], o_done[0], inj_cnt[0]);
    end
  endtask

  task automatic test_back_to_back();
    run_scn("b2b_first", 5, 0, 0, 0);
    run_scn("b2b_second", 0, 3, 0, 0);
    checks++;
    if (o_tmo[0] !== 1'b1 || o_done[0] !== 1'b0 || o_cnt[0] !== 32'd3 || rl_cnt[0] !== 8) begin
      errors++;
      $display("FAIL b2b_second tmo=%b done=%b cnt=%0d rstlow=%0d want 1/0/3/8", o_tmo[0], o_done[0], o_cnt[0], rl_cnt[0]);
    end
  endtask

  task automatic test_random();
    int eot, to, len, want_stb;
    bit by_eot;
    for (int n = 0; n < 12; n++) begin
      eot = $urandom_range(0, 25);
      to  = $urandom_range(0, 25);
      if (eot == 0 && to == 0) to = 1;
      by_eot = (eot > 0) && (to == 0 || eot <= to);
      len    = by_eot ? eot : to;
      run_scn("rand", eot, to, 0, 0);
      for (int i = 0; i < 2; i++) begin
        want_stb = (len + div_of(i) - 1) / div_of(i) + (by_eot ? drn_of(i) : 0);
        checks++;
        if (st_cnt[i] !== want_stb || o_cnt[i] !== 32'(len) || o_done[i] !== by_eot || o_tmo[i] !== !by_eot) begin
          errors++;
          $display("FAIL rand inst%0d eot=%0d to=%0d stb=%0d cnt=%0d done=%b tmo=%b want %0d/%0d/%b/%b",
                   i, eot, to, st_cnt[i], o_cnt[i], o_done[i], o_tmo[i], want_stb, len, by_eot, !by_eot);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_eot_default();
    test_div3();
    test_timeout();
    test_abort();
    test_rst_midrun();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
